instr_sequencer: RTL and testbench

//  Multi-cycle control FSM that runs one 8-bit instruction (opcode[7:4], addr[3:0]) on the

---
 rtl/instr_sequencer_pkg.sv | 21 ++
 rtl/instr_sequencer_if.sv | 23 ++
 rtl/instr_sequencer_op_decode.sv | 31 +++
 rtl/instr_sequencer.sv | 77 +++++++
 tb/tb_instr_sequencer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg: opcodes, ALU modes, FSM states and decoded control word.
package instr_sequencer_pkg;
  localparam logic [3:0] OP_LD = 4'h0, OP_ST = 4'h1, OP_MI = 4'h2, OP_MR = 4'h3;
  localparam logic [3:0] OP_SUM = 4'h4, OP_SB = 4'h5, OP_ANR = 4'h6, OP_CM = 4'h7;
  localparam logic [3:0] OP_ORR = 4'h8, OP_ORI = 4'h9, OP_XRR = 4'hA, OP_XRI = 4'hB;
  localparam logic [3:0] OP_SMI = 4'hC, OP_SBI = 4'hD, OP_ANI = 4'hE, OP_CMI = 4'hF;
  typedef enum logic [2:0] {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_CMP} alu_mode_t;
  typedef enum logic [2:0] {
    S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_EXEC, S_EX_WAIT, S_WB, S_WR, S_DONE
  } state_t;
  typedef struct packed {
    logic      rd_mem;
    logic      use_alu;
    logic      use_imm;
    logic      wr_acc;
    logic      wr_flags;
    logic      wr_mem;
    logic      wr_src;
    alu_mode_t mode;
  } ctrl_t;
endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: memory and ALU bus between the sequencer and the datapath.
interface instr_sequencer_if;
  logic       mem_enable;
  logic       read_write;
  logic [3:0] address_bus;
  logic [7:0] data_bus_in;
  logic [7:0] mem_rdata;
  logic       alu_enable;
  logic [2:0] mode;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       alu_carry;
  modport master (
    output mem_enable, read_write, address_bus, data_bus_in, alu_enable, mode, alu_a, alu_b,
    input  mem_rdata, alu_result, alu_zero, alu_carry
  );
  modport slave (
    input  mem_enable, read_write, address_bus, data_bus_in, alu_enable, mode, alu_a, alu_b,
    output mem_rdata, alu_result, alu_zero, alu_carry
  );
endinterface

// File: rtl/instr_sequencer_op_decode.sv
// op_decode: opcode to control word for the sequencer.
module op_decode
  import instr_sequencer_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);
  logic imm_form;
  assign imm_form = opcode inside {OP_SMI, OP_SBI, OP_ANI, OP_ORI, OP_XRI, OP_CMI};
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_LD: begin ctrl.rd_mem = 1'b1; ctrl.wr_acc = 1'b1; end
      OP_ST: ctrl.wr_mem = 1'b1;
      OP_MR: begin ctrl.wr_mem = 1'b1; ctrl.wr_src = 1'b1; ctrl.use_imm = 1'b1; end
      OP_MI: begin ctrl.use_imm = 1'b1; ctrl.wr_acc = 1'b1; end
      default: begin
        ctrl.use_alu  = 1'b1;
        ctrl.wr_flags = 1'b1;
        ctrl.use_imm  = imm_form;
        ctrl.rd_mem   = !imm_form;
        ctrl.wr_acc   = !(opcode inside {OP_CM, OP_CMI});
        ctrl.mode     = opcode inside {OP_SUM, OP_SMI} ? M_ADD :
                        opcode inside {OP_SB, OP_SBI}  ? M_SUB :
                        opcode inside {OP_ANR, OP_ANI} ? M_AND :
                        opcode inside {OP_ORR, OP_ORI} ? M_OR  :
                        opcode inside {OP_XRR, OP_XRI} ? M_XOR : M_CMP;
      end
    endcase
  end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle FSM running one instruction on the shared memory and ALU.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int ALU_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         instr,
  input  logic [7:0]         imm,
  instr_sequencer_if.master  bus,
  output logic [7:0]         acc,
  output logic               zero_flag,
  output logic               carry_flag,
  output logic               busy,
  output logic               done
);
  state_t     state, nxt;
  ctrl_t      ctl;
  logic [7:0] ir, b_q, res_q, cnt;
  logic       z_q, c_q, last, wr_go, alu_act;
  op_decode u_dec (.opcode(state == S_IDLE ? instr[7:4] : ir[7:4]), .ctrl(ctl));
  assign last = state == S_RD_WAIT ? cnt == 8'(MEM_LAT - 1) : cnt == 8'(ALU_LAT - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ir         <= '0;
      b_q        <= '0;
      res_q      <= '0;
      z_q        <= 1'b0;
      c_q        <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= nxt != state ? '0 : cnt + 8'd1;
      if (state == S_IDLE && start) begin
        ir  <= instr;
        b_q <= ctl.use_imm ? imm : '0;
      end
      if (state == S_RD_WAIT && last) b_q <= bus.mem_rdata;
      if (state == S_EX_WAIT && last) {c_q, z_q, res_q} <= {bus.alu_carry, bus.alu_zero, bus.alu_result};
      if (state == S_WB && ctl.wr_acc) acc <= ctl.use_alu ? res_q : b_q;
      if (state == S_WB && ctl.wr_flags) {carry_flag, zero_flag} <= {c_q, z_q};
    end
  end
  // A write still in flight when reset arrives must never reach the memory.
  assign wr_go   = state == S_WR && !reset;
  assign alu_act = state == S_EXEC || state == S_EX_WAIT;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:     if (start) nxt = ctl.rd_mem ? S_RD_ISSUE : ctl.use_alu ? S_EXEC : ctl.wr_mem ? S_WR : S_WB;
      S_RD_ISSUE: nxt = S_RD_WAIT;
      S_RD_WAIT:  if (last) nxt = ctl.use_alu ? S_EXEC : S_WB;
      S_EXEC:     nxt = S_EX_WAIT;
      S_EX_WAIT:  if (last) nxt = S_WB;
      S_WB:       nxt = S_DONE;
      S_WR:       nxt = S_DONE;
      default:    nxt = S_IDLE;
    endcase
    bus.mem_enable  = state == S_RD_ISSUE || wr_go;
    bus.read_write  = !wr_go;
    bus.address_bus = (state == S_RD_ISSUE || state == S_WR) ? ir[3:0] : '0;
    bus.data_bus_in = state == S_WR ? (ctl.wr_src ? b_q : acc) : '0;
    bus.alu_enable  = state == S_EXEC;
    bus.mode        = alu_act ? ctl.mode : M_ADD;
    bus.alu_a       = acc;
    bus.alu_b       = alu_act ? b_q : '0;
    busy            = state != S_IDLE;
    done            = state == S_DONE;
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed and random instructions checked against an ISA-level model.
module tb_instr_sequencer;
  logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [7:0] instr = '0, imm = '0, acc;
  logic       zero_flag, carry_flag, busy, done;
  int         checks = 0, errors = 0, alu_cnt = 0, wr_cnt = 0;
  logic [7:0] mem [16];
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] r_mem [16];
  logic [7:0] r_acc = '0;
  logic       r_z = 1'b0, r_c = 1'b0;
  instr_sequencer_if ifc();
  instr_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .imm(imm), .bus(ifc),
    .acc(acc), .zero_flag(zero_flag), .carry_flag(carry_flag), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  function automatic logic [9:0] env_alu(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    case (m)
      3'd0:       s = {1'b0, a} + {1'b0, b};
      3'd1, 3'd5: s = {1'b0, a} - {1'b0, b};
      3'd2:       s = {1'b0, a & b};
      3'd3:       s = {1'b0, a | b};
      3'd4:       s = {1'b0, a ^ b};
      default:    s = '0;
    endcase
    return {s[8], s[7:0] == 8'd0, s[7:0]};
  endfunction
  // Memory with one-cycle read latency and a one-cycle ALU, as the datapath provides.
  always @(posedge clk) begin
    if (ifc.mem_enable && ifc.read_write) ifc.mem_rdata <= mem[ifc.address_bus];
    if (ifc.mem_enable && !ifc.read_write) begin
      mem[ifc.address_bus] <= ifc.data_bus_in;
      wr_addr <= ifc.address_bus;
      wr_data <= ifc.data_bus_in;
      wr_cnt  <= wr_cnt + 1;
    end
    if (ifc.alu_enable) begin
      {ifc.alu_carry, ifc.alu_zero, ifc.alu_result} <= env_alu(ifc.mode, ifc.alu_a, ifc.alu_b);
      alu_cnt <= alu_cnt + 1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic ref_step(input logic [7:0] ins, input logic [7:0] im, output int lat, output int alus, output int wrs);
    logic [3:0] op, a;
    logic [7:0] b;
    logic [8:0] s;
    logic       imm_form;
    op = ins[7:4];
    a = ins[3:0];
    imm_form = op inside {4'hC, 4'hD, 4'hE, 4'h9, 4'hB, 4'hF};
    b = imm_form ? im : r_mem[a];
    alus = 0;
    wrs = 0;
    case (op)
      4'h0: begin r_acc = r_mem[a]; lat = 4; end
      4'h1: begin r_mem[a] = r_acc; lat = 2; wrs = 1; end
      4'h3: begin r_mem[a] = im; lat = 2; wrs = 1; end
      4'h2: begin r_acc = im; lat = 2; end
      default: begin
        alus = 1;
        lat = imm_form ? 4 : 6;
        if (op inside {4'h4, 4'hC}) begin
          s = {1'b0, r_acc} + {1'b0, b};
          r_c = s[8];
          r_acc = s[7:0];
          r_z = r_acc == 8'd0;
        end else if (op inside {4'h5, 4'hD}) begin
          r_c = r_acc < b;
          r_acc = r_acc - b;
          r_z = r_acc == 8'd0;
        end else if (op inside {4'h7, 4'hF}) begin
          r_c = r_acc < b;
          r_z = r_acc == b;
        end else begin
          r_acc = op inside {4'h6, 4'hE} ? r_acc & b : op inside {4'h8, 4'h9} ? r_acc | b : r_acc ^ b;
          r_c = 1'b0;
          r_z = r_acc == 8'd0;
        end
      end
    endcase
  endtask
  task automatic wait_done(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 20);
  endtask
  task automatic chk_state(input string tag);
    chk({tag, "_acc"}, 32'(acc), 32'(r_acc));
    chk({tag, "_zero"}, 32'(zero_flag), 32'(r_z));
    chk({tag, "_carry"}, 32'(carry_flag), 32'(r_c));
  endtask
  task automatic run_instr(input string tag, input logic [7:0] ins, input logic [7:0] im);
    int lat, alus, wrs, n, a0, w0;
    a0 = alu_cnt;
    w0 = wr_cnt;
    ref_step(ins, im, lat, alus, wrs);
    @(negedge clk);
    instr = ins; imm = im; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; instr = 8'($urandom); imm = 8'($urandom);
    wait_done(n);
    chk({tag, "_latency"}, n, lat);
    chk_state(tag);
    chk({tag, "_alu_pulses"}, alu_cnt - a0, alus);
    chk({tag, "_writes"}, wr_cnt - w0, wrs);
    chk({tag, "_mem"}, 32'(mem[ins[3:0]]), 32'(r_mem[ins[3:0]]));
    if (wrs == 1) begin
      chk({tag, "_wr_addr"}, 32'(wr_addr), 32'(ins[3:0]));
      chk({tag, "_wr_data"}, 32'(wr_data), 32'(r_mem[ins[3:0]]));
    end
  endtask
  task automatic chk_idle(input string tag);
    chk_state(tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_mem_enable"}, 32'(ifc.mem_enable), 0);
    chk({tag, "_read_write"}, 32'(ifc.read_write), 1);
    chk({tag, "_alu_enable"}, 32'(ifc.alu_enable), 0);
    chk({tag, "_address_bus"}, 32'(ifc.address_bus), 0);
    chk({tag, "_data_bus_in"}, 32'(ifc.data_bus_in), 0);
  endtask
  initial begin
    int n, w0, lat, alus, wrs;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_idle("reset");
    for (int i = 0; i < 16; i++) run_instr("preload", {4'h3, 4'(i)}, 8'($urandom));
    run_instr("t2_mr", 8'h35, 8'd9);
    run_instr("t2_mi", 8'h20, 8'd5);
    run_instr("t2_sum", 8'h45, 8'h00);
    chk("t2_acc14", 32'(acc), 32'd14);
    run_instr("t3_st", 8'h11, 8'h00);
    chk("t3_wdata14", 32'(wr_data), 32'd14);
    run_instr("t3_mi", 8'h20, 8'h00);
    run_instr("t3_ld", 8'h01, 8'h00);
    chk("t3_ld14", 32'(acc), 32'd14);
    run_instr("t4_mi", 8'h20, 8'hFF);
    run_instr("t4_smi", 8'hC0, 8'h01);
    chk("t4_wrap", 32'({acc, zero_flag, carry_flag}), 32'({8'h00, 1'b1, 1'b1}));
    run_instr("t4_cmi", 8'hF0, 8'h00);
    chk("t4_cmi_z", 32'({acc, zero_flag}), 32'({8'h00, 1'b1}));
    // Start stays high across a SUM; the second instruction waits for IDLE.
    ref_step(8'h45, 8'h00, lat, alus, wrs);
    @(negedge clk);
    instr = 8'h45; imm = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    instr = 8'h20; imm = 8'h33;
    wait_done(n);
    chk("t5_sum_latency", n, 6);
    chk_state("t5_sum");
    @(negedge clk);
    chk("t5_idle_gap", 32'(busy), 0);
    @(negedge clk);
    chk("t5_accepted", 32'(busy), 1);
    start = 1'b0;
    ref_step(8'h20, 8'h33, lat, alus, wrs);
    @(negedge clk);
    chk("t5_mi_done", 32'(done), 1);
    chk_state("t5_mi");
    // Reset in EX_WAIT of a SUM.
    ref_step(8'h45, 8'h00, lat, alus, wrs);
    @(negedge clk);
    instr = 8'h45; imm = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_exwait_busy", 32'(busy), 1);
    reset = 1'b1;
    r_acc = '0; r_z = 1'b0; r_c = 1'b0;
    @(negedge clk);
    chk_idle("t6_ex");
    reset = 1'b0;
    // Reset in WR of an MR must not commit the write.
    w0 = wr_cnt;
    @(negedge clk);
    instr = 8'h33; imm = ~r_mem[3]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("t6_wr_cycle", 32'({ifc.mem_enable, ifc.read_write}), 32'(2'b10));
    reset = 1'b1;
    @(negedge clk);
    chk_idle("t6_wr");
    chk("t6_no_write", wr_cnt - w0, 0);
    chk("t6_mem_kept", 32'(mem[3]), 32'(r_mem[3]));
    reset = 1'b0;
    for (int i = 0; i < 40; i++) run_instr("rand", 8'($urandom), 8'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
